// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: writeback stage of the pipelined MIPS core.
// Holds the MEM/WB pipeline entry, aligns and extends load data, selects
// the writeback source and drives the register-file write port.
// Loads wait in the stage until the data memory returns mem_rvalid.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, adds byp_valid/byp_wa/byp_wd, which present the last
//   retired nonzero-register write for ID-stage forwarding.
//
// Handshake: an instruction transfers from MEM when in_valid && in_ready
// on a rising edge, unless flush is high in that cycle (flush wins and the
// instruction is dropped). in_ready depends only on registered state, never
// on in_valid, so there is no combinational path from in_valid to in_ready.
module wb_stage_pipe #(
  parameter int DW       = 32,
  parameter int RAW      = 5,
  parameter int LINK_OFF = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  input  logic [31:0]    in_pc,
  input  logic [DW-1:0]  in_result,
  input  logic [DW-1:0]  in_dout,
  input  logic [1:0]     in_sel,
  input  logic [1:0]     in_ld_size,
  input  logic           in_ld_signed,
  input  logic           in_we,
  input  logic [RAW-1:0] in_wa,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_rvalid,
  output logic           rf_we,
  output logic [RAW-1:0] rf_wa,
  output logic [DW-1:0]  rf_wd,
  output logic           busy,
  output logic [1:0]     state_dbg
`ifdef WB_BYPASS_EN
  ,
  output logic           byp_valid,
  output logic [RAW-1:0] byp_wa,
  output logic [DW-1:0]  byp_wd
`endif
);

  // Number of byte-offset bits inside one datapath word.
  localparam int OW = $clog2(DW / 8);

  // Writeback source encodings.
  localparam logic [1:0] SEL_RESULT = 2'd0;
  localparam logic [1:0] SEL_MEM    = 2'd1;
  localparam logic [1:0] SEL_LINK   = 2'd2;
  localparam logic [1:0] SEL_DOUT   = 2'd3;

  // Load size encodings.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // empty
    HOLD = 2'd1,  // non-load captured, retiring this cycle
    WAIT = 2'd2,  // load captured, waiting for mem_rvalid
    DONE = 2'd3   // load data latched, retiring this cycle
  } state_t;

  state_t state;
  state_t state_nx;

  logic           capture;
  logic           we_q;
  logic [RAW-1:0] wa_q;
  logic [OW-1:0]  off_q;
  logic [1:0]     size_q;
  logic           signed_q;

  logic [31:0]    link_val;
  logic [DW-1:0]  alu_wd;
  logic [DW-1:0]  load_wd;

  // Selects the lane addressed by off and sign/zero-extends it to DW.
  // Misaligned half/word offsets floor to the containing lane. A dword
  // request returns the whole word: for DW=64 that is the dword, and for
  // DW=32 the single word lane is the whole bus, matching word behaviour.
  function automatic logic [DW-1:0] ld_extend(
    input logic [DW-1:0] data,
    input logic [OW-1:0] off,
    input logic [1:0]    size,
    input logic          sgn
  );
    logic [5:0]  bsh;
    logic [5:0]  hsh;
    logic [5:0]  wsh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [DW-1:0] res;
    bsh = 6'({off, 3'b000});
    hsh = 6'({off[OW-1:1], 4'b0000});
    if (DW == 64) begin
      wsh = 6'({off[OW-1], 5'b00000});
    end else begin
      wsh = 6'd0;
    end
    b = 8'(data >> bsh);
    h = 16'(data >> hsh);
    w = 32'(data >> wsh);
    case (size)
      SZ_BYTE: begin
        if (sgn) res = DW'($signed(b));
        else     res = DW'(b);
      end
      SZ_HALF: begin
        if (sgn) res = DW'($signed(h));
        else     res = DW'(h);
      end
      SZ_WORD: begin
        if (sgn) res = DW'($signed(w));
        else     res = DW'(w);
      end
      default: res = data;
    endcase
    return res;
  endfunction

  // Handshake, capture qualification and next-state logic.
  always_comb begin
    state_nx = state;
    in_ready = (state != WAIT);
    busy     = (state != IDLE);
    capture  = in_valid && in_ready && !flush;
    if (capture) begin
      state_nx = (in_sel == SEL_MEM) ? WAIT : HOLD;
    end else begin
      case (state)
        HOLD:    state_nx = IDLE;
        DONE:    state_nx = IDLE;
        WAIT:    if (mem_rvalid) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Writeback value for non-load sources, formed from the presented inputs
  // so it can be registered on the capture edge. Link adds in 32 bits and
  // wraps before zero-extension to DW.
  always_comb begin
    link_val = in_pc + 32'(LINK_OFF);
    case (in_sel)
      SEL_LINK: alu_wd = DW'(link_val);
      SEL_DOUT: alu_wd = in_dout;
      default:  alu_wd = in_result;
    endcase
    load_wd = ld_extend(mem_rdata, off_q, size_q, signed_q);
  end

  // Pipeline entry fields needed later by a load waiting for its data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      wa_q     <= '0;
      off_q    <= '0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
    end else if (capture) begin
      we_q     <= in_we;
      wa_q     <= in_wa;
      off_q    <= in_result[OW-1:0];
      size_q   <= in_ld_size;
      signed_q <= in_ld_signed;
    end
  end

  // Register-file write port: rf_we pulses for the single cycle the entry
  // spends in HOLD or DONE; address and data change only when a real write
  // is about to retire, so they hold their last values otherwise. Writes to
  // register 0 never pulse rf_we.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= 1'b0;
      if (capture && (in_sel != SEL_MEM)) begin
        if (in_we && (in_wa != '0)) begin
          rf_we <= 1'b1;
          rf_wa <= in_wa;
          rf_wd <= alu_wd;
        end
      end else if ((state == WAIT) && mem_rvalid) begin
        if (we_q && (wa_q != '0)) begin
          rf_we <= 1'b1;
          rf_wa <= wa_q;
          rf_wd <= load_wd;
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Remembers the most recent retired register write for ID forwarding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_valid <= 1'b0;
      byp_wa    <= '0;
      byp_wd    <= '0;
    end else if (rf_we) begin
      byp_valid <= 1'b1;
      byp_wa    <= rf_wa;
      byp_wd    <= rf_wd;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Testbench for wb_stage_pipe (DW=32, RAW=5, LINK_OFF=8).
module tb_wb_stage_pipe;

  localparam int DW       = 32;
  localparam int RAW      = 5;
  localparam int LINK_OFF = 8;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [31:0]    in_pc;
  logic [DW-1:0]  in_result;
  logic [DW-1:0]  in_dout;
  logic [1:0]     in_sel;
  logic [1:0]     in_ld_size;
  logic           in_ld_signed;
  logic           in_we;
  logic [RAW-1:0] in_wa;
  logic [DW-1:0]  mem_rdata;
  logic           mem_rvalid;
  logic           rf_we;
  logic [RAW-1:0] rf_wa;
  logic [DW-1:0]  rf_wd;
  logic           busy;
  logic [1:0]     state_dbg;
`ifdef WB_BYPASS_EN
  logic           byp_valid;
  logic [RAW-1:0] byp_wa;
  logic [DW-1:0]  byp_wd;
`endif

  wb_stage_pipe #(.DW(DW), .RAW(RAW), .LINK_OFF(LINK_OFF)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .in_pc(in_pc), .in_result(in_result), .in_dout(in_dout),
    .in_sel(in_sel), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_we(in_we), .in_wa(in_wa),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy(busy), .state_dbg(state_dbg)
`ifdef WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_wa(byp_wa), .byp_wd(byp_wd)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [RAW+DW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        sgn;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] dout;
    logic [31:0] rdata;
    int          lat;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [1:0] size, input logic sgn,
                              input logic we, input logic [4:0] wa, input logic [31:0] pc,
                              input logic [31:0] result, input logic [31:0] dout,
                              input logic [31:0] rdata, input int lat,
                              input logic exp_we, input logic [31:0] exp_wd);
    vec_t v;
    v.sel = sel; v.size = size; v.sgn = sgn; v.we = we; v.wa = wa; v.pc = pc;
    v.result = result; v.dout = dout; v.rdata = rdata; v.lat = lat;
    v.exp_we = exp_we; v.exp_wd = exp_wd;
    return v;
  endfunction

  // Scoreboard: every retirement must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", rf_wa, rf_wd);
      end else begin
        check("retire", {rf_wa, rf_wd}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks.
  task automatic idle_inputs();
    in_valid = 0; flush = 0; in_pc = 0; in_result = 0; in_dout = 0;
    in_sel = 0; in_ld_size = 0; in_ld_signed = 0; in_we = 0; in_wa = 0;
    mem_rdata = 0; mem_rvalid = 0;
  endtask

  task automatic drive_alu(input logic [4:0] wa, input logic [31:0] result, input logic push);
    in_valid = 1; in_sel = 2'd0; in_we = 1; in_wa = wa; in_result = result;
    if (push) exp_q.push_back({wa, result});
  endtask

  // Applies one vector and walks it through to retirement.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    in_valid = 1; in_sel = v.sel; in_ld_size = v.size; in_ld_signed = v.sgn;
    in_we = v.we; in_wa = v.wa; in_pc = v.pc; in_result = v.result; in_dout = v.dout;
    if (v.sel == 2'd1) begin
      // data returned in the capture cycle belongs to nobody and must be ignored
      mem_rvalid = 1; mem_rdata = ~v.rdata;
    end else if (v.exp_we) begin
      exp_q.push_back({v.wa, v.exp_wd});
    end
    @(negedge clk);
    in_valid = 0; mem_rvalid = 0;
    if (v.sel == 2'd1) begin
      check($sformatf("vec%0d_wait_ready", idx), in_ready, 0);
      repeat (v.lat - 1) begin
        @(negedge clk);
        check($sformatf("vec%0d_wait_ready", idx), in_ready, 0);
      end
      mem_rvalid = 1; mem_rdata = v.rdata;
      if (v.exp_we) exp_q.push_back({v.wa, v.exp_wd});
      @(negedge clk);
      mem_rvalid = 0;
    end
    check($sformatf("vec%0d_rf_we", idx), rf_we, v.exp_we);
    check($sformatf("vec%0d_ready", idx), in_ready, 1);
    @(negedge clk);
    check($sformatf("vec%0d_busy_after", idx), busy, 0);
  endtask

  initial begin
    vecs[0]  = mk(2'd0, 2'd0, 0, 1, 5'd3,  0,            32'h11,       0,            0,            1, 1, 32'h11);
    vecs[1]  = mk(2'd1, 2'd0, 1, 1, 5'd8,  0,            32'h1003,     0,            32'h80FF0000, 3, 1, 32'hFFFFFF80);
    vecs[2]  = mk(2'd1, 2'd1, 0, 1, 5'd9,  0,            32'h1002,     0,            32'hABCD1234, 1, 1, 32'h0000ABCD);
    vecs[3]  = mk(2'd1, 2'd1, 1, 1, 5'd9,  0,            32'h1002,     0,            32'hABCD1234, 2, 1, 32'hFFFFABCD);
    vecs[4]  = mk(2'd2, 2'd0, 0, 1, 5'd31, 32'h00400010, 32'h5,        0,            0,            1, 1, 32'h00400018);
    vecs[5]  = mk(2'd3, 2'd0, 0, 1, 5'd7,  0,            32'h1,        32'hDEADBEEF, 0,            1, 1, 32'hDEADBEEF);
    vecs[6]  = mk(2'd0, 2'd0, 0, 1, 5'd0,  0,            32'h99,       0,            0,            1, 0, 0);
    vecs[7]  = mk(2'd1, 2'd0, 0, 1, 5'd10, 0,            32'h2000,     0,            32'h123456F0, 1, 1, 32'h000000F0);
    vecs[8]  = mk(2'd1, 2'd0, 1, 1, 5'd10, 0,            32'h2000,     0,            32'h123456F0, 1, 1, 32'hFFFFFFF0);
    vecs[9]  = mk(2'd1, 2'd0, 1, 1, 5'd11, 0,            32'h2001,     0,            32'h123456F0, 2, 1, 32'h00000056);
    vecs[10] = mk(2'd1, 2'd2, 1, 1, 5'd12, 0,            32'h3003,     0,            32'hCAFEBABE, 1, 1, 32'hCAFEBABE);
    vecs[11] = mk(2'd1, 2'd1, 1, 1, 5'd13, 0,            32'h4001,     0,            32'h80017FFE, 1, 1, 32'h00007FFE);
    vecs[12] = mk(2'd1, 2'd1, 1, 1, 5'd13, 0,            32'h4003,     0,            32'h80017FFE, 1, 1, 32'hFFFF8001);
    vecs[13] = mk(2'd1, 2'd3, 1, 1, 5'd14, 0,            32'h5000,     0,            32'h89ABCDEF, 1, 1, 32'h89ABCDEF);
    vecs[14] = mk(2'd2, 2'd0, 0, 1, 5'd15, 32'hFFFFFFFC, 0,            0,            0,            1, 1, 32'h00000004);
    vecs[15] = mk(2'd1, 2'd2, 0, 1, 5'd0,  0,            32'h6000,     0,            32'h77777777, 1, 0, 0);

    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_wa", rf_wa, 0);
    check("reset_rf_wd", rf_wd, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    reset = 0;
    @(negedge clk);
    check("post_reset_state", state_dbg, 0);

    // Table-driven vectors with random idle gaps between them.
    for (int i = 0; i < 16; i++) begin
      run_vec(i, vecs[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Back-to-back ALU ops retire on consecutive cycles.
    @(negedge clk);
    drive_alu(5'd3, 32'h11, 1);
    check("b2b_ready0", in_ready, 1);
    @(negedge clk);
    drive_alu(5'd4, 32'h22, 1);
    check("b2b_ready1", in_ready, 1);
    check("b2b_we0", rf_we, 1);
    check("b2b_wa0", rf_wa, 3);
    @(negedge clk);
    idle_inputs();
    check("b2b_we1", rf_we, 1);
    check("b2b_wa1", rf_wa, 4);
    check("b2b_wd1", rf_wd, 32'h22);
    @(negedge clk);
    check("b2b_we_end", rf_we, 0);
    check("b2b_busy_end", busy, 0);

    // A load in DONE retires while the next instruction is captured.
    @(negedge clk);
    in_valid = 1; in_sel = 2'd1; in_ld_size = 2'd2; in_we = 1; in_wa = 5'd9; in_result = 32'h2000;
    @(negedge clk);
    in_valid = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    exp_q.push_back({5'd9, 32'h12345678});
    @(negedge clk);
    mem_rvalid = 0;
    check("done_ready", in_ready, 1);
    check("done_we", rf_we, 1);
    drive_alu(5'd10, 32'hAB, 1);
    @(negedge clk);
    idle_inputs();
    check("done_next_wa", rf_wa, 10);
    @(negedge clk);
    check("done_busy_end", busy, 0);

    // Flush from IDLE: nothing captured.
    @(negedge clk);
    drive_alu(5'd6, 32'h66, 0);
    flush = 1;
    @(negedge clk);
    idle_inputs();
    check("flush_idle_busy", busy, 0);
    check("flush_idle_we", rf_we, 0);

    // Flush while HOLD retires: the held entry still writes, the new one is dropped.
    @(negedge clk);
    drive_alu(5'd6, 32'h66, 1);
    @(negedge clk);
    drive_alu(5'd7, 32'h77, 0);
    flush = 1;
    check("flush_hold_we", rf_we, 1);
    @(negedge clk);
    idle_inputs();
    check("flush_hold_busy", busy, 0);
    check("flush_hold_we_end", rf_we, 0);

    // Flushed load from IDLE.
    @(negedge clk);
    in_valid = 1; flush = 1; in_sel = 2'd1; in_we = 1; in_wa = 5'd12;
    @(negedge clk);
    idle_inputs();
    check("flush_load_busy", busy, 0);
    check("flush_load_ready", in_ready, 1);

    // Reset in the middle of WAIT discards the load.
    @(negedge clk);
    in_valid = 1; in_sel = 2'd1; in_ld_size = 2'd2; in_we = 1; in_wa = 5'd5; in_result = 32'h100;
    @(negedge clk);
    idle_inputs();
    check("rst_wait_ready", in_ready, 0);
    check("rst_wait_busy", busy, 1);
    check("rst_wait_state", state_dbg, 2);
    reset = 1;
    #1;
    check("rst_mid_we", rf_we, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;
    mem_rvalid = 1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 0;
    check("rst_late_rvalid_we", rf_we, 0);
    check("rst_late_rvalid_busy", busy, 0);
    @(negedge clk);
    check("rst_late_rvalid_we2", rf_we, 0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
